// File: rtl/reg_read_port.sv
// General-purpose register bank with one write port and a two-operand
// registered read port behind a valid/ready handshake with write-to-read bypass.
module reg_read_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic              rd_ready,
  output logic              rd_accept,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]        state, state_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] cap_a, cap_b;

  assign rd_valid  = (state == FULL);
  assign rd_accept = rd_req & (~rd_valid | rd_ready);

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    cap_a = '0;
    if (raddr_a != '0) begin
      cap_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
    end
  end

  always_comb begin
    cap_b = '0;
    if (raddr_b != '0) begin
      cap_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];
    end
  end

  always_comb begin
    state_nxt = state;
    if (rd_accept) begin
      state_nxt = FULL;
    end else if (rd_ready) begin
      state_nxt = EMPTY;
    end
  end

  // Data registers only load on accept, so a stalled result stays frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      state <= state_nxt;
      if (rd_accept) begin
        rdata_a <= cap_a;
        rdata_b <= cap_b;
      end
    end
  end

endmodule

// File: tb/tb_reg_read_port.sv
// Self-checking bench for reg_read_port: directed scenarios followed by random
// traffic checked against a behavioural register-file model.
module tb_reg_read_port;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        rd_req;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic        rd_ready;
  logic        rd_accept;
  logic        rd_valid;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_a, m_b;

  reg_read_port #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .rd_req   (rd_req),
    .raddr_a  (raddr_a),
    .raddr_b  (raddr_b),
    .rd_ready (rd_ready),
    .rd_accept(rd_accept),
    .rd_valid (rd_valid),
    .rdata_a  (rdata_a),
    .rdata_b  (rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] ra, input logic w,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
    if (w && wa == ra) return wd;
    return m_regs[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0;
    m_a = 32'd0;
    m_b = 32'd0;
  endtask

  // One clock cycle: drive inputs, check the combinational accept, advance the
  // model at the edge, then check the registered outputs.
  task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic req, input logic [4:0] ra, input logic [4:0] rb,
                      input logic rdy);
    logic acc;
    we = w; waddr = wa; wdata = wd;
    rd_req = req; raddr_a = ra; raddr_b = rb; rd_ready = rdy;
    #1;
    acc = req && (!m_valid || rdy);
    chk("rd_accept", {31'd0, rd_accept}, {31'd0, acc});
    @(posedge clk);
    if (acc) begin
      m_a = model_read(ra, w, wa, wd);
      m_b = model_read(rb, w, wa, wd);
      m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    if (w && wa != 5'd0) m_regs[wa] = wd;
    #1;
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk("rdata_a", rdata_a, m_a);
      chk("rdata_b", rdata_b, m_b);
    end
  endtask

  initial begin
    we = 0; waddr = 0; wdata = 0; rd_req = 0; raddr_a = 0; raddr_b = 0; rd_ready = 0;
    rst_n = 1'b0;
    model_clear();
    #22;
    chk("reset_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_rdata_a", rdata_a, 32'd0);
    chk("reset_rdata_b", rdata_b, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write r5 then read A=5, B=0
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1);
    step(0, 0, 0, 1, 5'd5, 5'd0, 1);
    chk("r5_read", rdata_a, 32'hDEADBEEF);
    chk("r0_portb", rdata_b, 32'd0);

    // Writes to r0 are ignored
    step(1, 5'd0, 32'h12345678, 0, 0, 0, 1);
    step(0, 0, 0, 1, 5'd0, 5'd0, 1);
    chk("r0_ignored", rdata_a, 32'd0);

    // Same-cycle bypass on both ports
    step(1, 5'd7, 32'h1, 0, 0, 0, 1);
    step(1, 5'd7, 32'hA5A5A5A5, 1, 5'd7, 5'd7, 1);
    chk("bypass_a", rdata_a, 32'hA5A5A5A5);
    chk("bypass_b", rdata_b, 32'hA5A5A5A5);

    // Stall with snapshot while the source register changes
    step(1, 5'd3, 32'h11, 0, 0, 0, 1);
    step(0, 0, 0, 1, 5'd3, 5'd0, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 5'd3, 32'h22, 1, 5'd3, 5'd0, 0);
      chk("stall_accept", {31'd0, rd_accept}, 32'd0);
      chk("stall_snapshot", rdata_a, 32'h11);
    end
    step(0, 0, 0, 1, 5'd3, 5'd0, 1);
    chk("after_stall", rdata_a, 32'h22);

    // Back-to-back throughput
    for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'(i), 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 1, 5'(i), 5'(5 - i), 1);
      chk("b2b_data", rdata_a, 32'(i));
      chk("b2b_valid", {31'd0, rd_valid}, 32'd1);
    end
    step(0, 0, 0, 0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset while holding a result
    step(1, 5'd9, 32'h55, 0, 0, 0, 1);
    step(0, 0, 0, 1, 5'd9, 5'd9, 0);
    chk("pre_reset_a", rdata_a, 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, rd_valid}, 32'd0);
    chk("async_rdata_a", rdata_a, 32'd0);
    chk("async_rdata_b", rdata_b, 32'd0);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 5'(2 * i), 5'(2 * i + 1), 1);
      chk("post_reset_a", rdata_a, 32'd0);
      chk("post_reset_b", rdata_b, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
